// File: rtl/uart_pkg.sv
// Shared definitions for the user UART receiver: FSM states, read-word
// bit positions and the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int RD_VALID_BIT   = 8;
    localparam int RD_OVERRUN_BIT = 9;
    localparam int RD_FERR_BIT    = 10;

    localparam int CLK_DIV_DEFAULT = 434;

endpackage

// File: rtl/user_uart_rx_sync_fifo.sv
// Synchronous FIFO with show-ahead head output; DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/user_uart_rx.sv
// 8N1 UART receiver as a naive_bus read slave. Define USER_UART_RX_FIFO_EN for a
// FIFO_DEPTH-entry receive FIFO; otherwise a single holding register is used.
module user_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_uart_rx,
    input  logic        rd_req,
    output logic        rd_gnt,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        wr_req,
    output logic        wr_gnt,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be
);

    localparam logic [15:0] HALF_BIT = 16'(CLK_DIV / 2);
    localparam logic [15:0] FULL_BIT = 16'(CLK_DIV);

    logic        sync1_r, sync2_r, rx_prev_r;
    rx_state_e   state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic        push_s, ferr_set_s, fall_s;
    logic        push_ok_s, pop_s, ovr_set_s;
    logic        full_s, empty_s;
    logic [7:0]  head_s;
    logic        overrun_r, frame_err_r;
    logic [31:0] rd_word_s, rd_data_r;
    logic        unused_s;

    assign unused_s = ^{rd_addr, wr_addr, wr_data, wr_be};

    // Two-flop synchroniser plus one-cycle history for start-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= i_uart_rx;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    assign fall_s = rx_prev_r & ~sync2_r;

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 16'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Next-state logic; a count of 1 marks the last cycle of an interval, so the
    // interval length equals the value loaded.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        push_s        = 1'b0;
        ferr_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_nxt_s = START;
                    cnt_nxt_s   = HALF_BIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == 16'd1) begin
                    if (!sync2_r) begin
                        state_nxt_s   = DATA;
                        cnt_nxt_s     = FULL_BIT;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = 16'd0;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            DATA: begin
                if (cnt_r == 16'd1) begin
                    shift_nxt_s = {sync2_r, shift_r[7:1]};
                    cnt_nxt_s   = FULL_BIT;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s   = STOP;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            STOP: begin
                if (cnt_r == 16'd1) begin
                    push_s      = sync2_r;
                    ferr_set_s  = ~sync2_r;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase
    end

    // A full buffer still accepts a byte when the head leaves in the same cycle.
    assign pop_s     = rd_req & ~empty_s;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovr_set_s = push_s & full_s & ~pop_s;

`ifdef USER_UART_RX_FIFO_EN
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok_s),
        .pop   (pop_s),
        .din   (shift_r),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );
`else
    logic        hold_valid_r;
    logic [7:0]  hold_data_r;
    logic [31:0] unused_depth_s;

    assign unused_depth_s = 32'(FIFO_DEPTH);

    // Single-entry holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'd0;
        end else if (push_ok_s) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= shift_r;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    assign full_s  = hold_valid_r;
    assign empty_s = ~hold_valid_r;
    assign head_s  = hold_data_r;
`endif

    // Sticky error flags: cleared by any read unless set again that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overrun_r   <= ovr_set_s  | (overrun_r   & ~rd_req);
            frame_err_r <= ferr_set_s | (frame_err_r & ~rd_req);
        end
    end

    always_comb begin
        rd_word_s                 = 32'd0;
        rd_word_s[7:0]            = empty_s ? 8'd0 : head_s;
        rd_word_s[RD_VALID_BIT]   = ~empty_s;
        rd_word_s[RD_OVERRUN_BIT] = overrun_r;
        rd_word_s[RD_FERR_BIT]    = frame_err_r;
    end

    // Read data register holds until the next granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 32'd0;
        end else if (rd_req) begin
            rd_data_r <= rd_word_s;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_gnt  = rd_req;
    assign wr_gnt  = wr_req;
    assign rd_data = rd_data_r;

endmodule

// File: tb/tb_user_uart_rx.sv
// Directed bench for user_uart_rx at CLK_DIV=16; honours USER_UART_RX_FIFO_EN.
module tb_user_uart_rx;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 16;
`ifdef USER_UART_RX_FIFO_EN
    localparam int DEPTH_EFF = FIFO_DEPTH;
`else
    localparam int DEPTH_EFF = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_uart_rx = 1'b1;
    logic        rd_req = 1'b0;
    logic        rd_gnt;
    logic [31:0] rd_addr = 32'h0004_0000;
    logic [31:0] rd_data;
    logic        wr_req = 1'b0;
    logic        wr_gnt;
    logic [31:0] wr_addr = 32'h0004_0000;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  wr_be = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [6];

    user_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_uart_rx (i_uart_rx),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_gnt    (wr_gnt),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic hold_bit(input logic v);
        i_uart_rx = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        i_uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_read(output logic [31:0] d, output logic g);
        @(negedge clk);
        rd_req = 1'b1;
        #1 g = rd_gnt;
        @(negedge clk);
        rd_req = 1'b0;
        d = rd_data;
    endtask

    logic [31:0] d;
    logic        g;
    logic [31:0] exp;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 32'h0000_01A5, 32'h0000_0000};
        vecs[1] = '{8'h3C, 1'b0, 32'h0000_0400, 32'h0000_0000};
        vecs[2] = '{8'h00, 1'b1, 32'h0000_0100, 32'h0000_0000};
        vecs[3] = '{8'hFF, 1'b1, 32'h0000_01FF, 32'h0000_0000};
        vecs[4] = '{8'h81, 1'b1, 32'h0000_0181, 32'h0000_0000};
        vecs[5] = '{8'h5A, 1'b0, 32'h0000_0400, 32'h0000_0000};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_rd_data", rd_data, 32'h0);
        check("idle_rd_gnt", {31'd0, rd_gnt}, 32'd0);
        check("idle_wr_gnt", {31'd0, wr_gnt}, 32'd0);
        bus_read(d, g);
        check("reset_read", d, 32'h0);
        check("reset_read_gnt", {31'd0, g}, 32'd1);

        @(negedge clk);
        wr_req = 1'b1;
        wr_data = 32'hFFFF_FFFF;
        wr_be = 4'hF;
        #1 check("wr_gnt", {31'd0, wr_gnt}, 32'd1);
        @(negedge clk);
        wr_req = 1'b0;
        check("hold_after_write", rd_data, 32'h0);

        // Short low glitch on an idle line must not produce a byte.
        @(negedge clk);
        i_uart_rx = 1'b0;
        @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        bus_read(d, g);
        check("glitch_read", d, 32'h0);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            bus_read(d, g);
            check($sformatf("vec%0d_read1", i), d, vecs[i].exp1);
            bus_read(d, g);
            check($sformatf("vec%0d_read2", i), d, vecs[i].exp2);
        end

        // Overflow: FIFO_DEPTH+1 bytes with no reads, then back-to-back reads.
        for (int i = 0; i <= FIFO_DEPTH; i++) send_frame(8'(i), 1'b1);
        @(negedge clk);
        rd_req = 1'b1;
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            @(negedge clk);
            exp = 32'h0;
            if (i < DEPTH_EFF) exp = 32'h100 | 32'(i);
            if (i == 0) exp = exp | 32'h200;
            check($sformatf("ovf_read%0d", i), rd_data, exp);
        end
        rd_req = 1'b0;
        @(negedge clk);
        check("ovf_hold", rd_data, 32'h0);

        // Reset in the middle of the data bits aborts the frame.
        @(negedge clk);
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        rst = 1'b1;
        i_uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("midrst_rd_data", rd_data, 32'h0);
        bus_read(d, g);
        check("midrst_read", d, 32'h0);
        send_frame(8'h5A, 1'b1);
        bus_read(d, g);
        check("post_rst_5a", d, 32'h0000_015A);
        bus_read(d, g);
        check("post_rst_empty", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
